// File: rtl/parity_frame_checker_if.sv
// ---------------------------------------------------------------------------
// parity_frame_checker_if
//
// Bundles the serial input stream and the word-level results of
// parity_frame_checker.
//
//   master : drives in_valid/in/odd_mode/abort and observes the results
//   slave  : the checker; consumes the stream and drives the results
//
// Signals
//   in_valid    qualifies `in`
//   in          serial bit (data LSB first, then the parity bit)
//   odd_mode    0 = even parity, 1 = odd parity (sampled at data bit 0)
//   abort       discards the frame in progress
//   state       running XOR of the data bits accepted in this frame
//   bit_cnt     data bits accepted in this frame (saturates at DATA_W-1)
//   data_out    data word of the last completed frame
//   frame_valid one-cycle pulse on frame completion
//   parity_err  error flag of the last completed frame
// ---------------------------------------------------------------------------
interface parity_frame_checker_if #(
   parameter int DATA_W = 8,
   parameter int CNT_W  = $clog2(DATA_W)
);
   logic              in_valid;
   logic              in;
   logic              odd_mode;
   logic              abort;
   logic              state;
   logic [CNT_W-1:0]  bit_cnt;
   logic [DATA_W-1:0] data_out;
   logic              frame_valid;
   logic              parity_err;

   modport master (
      output in_valid, in, odd_mode, abort,
      input  state, bit_cnt, data_out, frame_valid, parity_err
   );

   modport slave (
      input  in_valid, in, odd_mode, abort,
      output state, bit_cnt, data_out, frame_valid, parity_err
   );
endinterface

// File: rtl/parity_frame_checker.sv
// ---------------------------------------------------------------------------
// parity_frame_checker
//
// Serial parity-frame checker. A frame is DATA_W data bits (LSB first)
// followed by one parity bit. Each completed frame presents the
// deserialised word, a parity error flag and a one-cycle frame_valid pulse.
//
// Optional feature macro: PARITY_ERR_CNT_EN
//   defined   -> err_cnt port with an ERR_W-bit saturating error counter
//   undefined -> no err_cnt port, ERR_W unused
//
// Ports
//   clk  rising-edge clock
//   rst  synchronous active-high reset (priority over abort and in_valid)
//   bus  parity_frame_checker_if.slave (stream in, results out)
//   err_cnt  saturating parity-error count (PARITY_ERR_CNT_EN only)
//
// All outputs are registered.
// ---------------------------------------------------------------------------
module parity_frame_checker #(
   parameter int DATA_W = 8,
   parameter int ERR_W  = 8,
   parameter int CNT_W  = $clog2(DATA_W)
) (
   input  logic                  clk,
   input  logic                  rst,
   parity_frame_checker_if.slave bus
`ifdef PARITY_ERR_CNT_EN
   ,
   output logic [ERR_W-1:0]      err_cnt
`endif
);

   if (DATA_W < 2 || ERR_W < 1) begin : g_bad_param
      $error("parity_frame_checker: DATA_W must be >= 2 and ERR_W >= 1");
   end

   typedef enum logic {
      S_DATA = 1'b0,
      S_PAR  = 1'b1
   } fsm_t;

   localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(DATA_W - 1);

   fsm_t              fsm_q, fsm_d;
   logic [DATA_W-1:0] shreg_q, shreg_d;
   logic              mode_q, mode_d;
   logic              par_q, par_d;
   logic [CNT_W-1:0]  cnt_q, cnt_d;
   logic [DATA_W-1:0] data_q, data_d;
   logic              fv_q, fv_d;
   logic              perr_q, perr_d;
   logic              err_inc;

   // Next-state and next-output logic. abort outranks in_valid; rst is
   // handled in the register process and outranks both.
   always_comb begin
      fsm_d   = fsm_q;
      shreg_d = shreg_q;
      mode_d  = mode_q;
      par_d   = par_q;
      cnt_d   = cnt_q;
      data_d  = data_q;
      fv_d    = 1'b0;
      perr_d  = perr_q;
      err_inc = 1'b0;

      if (bus.abort) begin
         fsm_d = S_DATA;
         cnt_d = '0;
         par_d = 1'b0;
      end else if (bus.in_valid) begin
         case (fsm_q)
            S_DATA: begin
               // Enter from the MSB side so that after DATA_W bits the
               // first (LSB) bit has arrived at bit 0.
               shreg_d = {bus.in, shreg_q[DATA_W-1:1]};
               par_d   = par_q ^ bus.in;
               if (cnt_q == '0) begin
                  mode_d = bus.odd_mode;
               end
               // The counter stops at DATA_W-1; the FSM state tells the
               // final data bit has been taken.
               if (cnt_q == LAST_CNT) begin
                  fsm_d = S_PAR;
               end else begin
                  cnt_d = cnt_q + CNT_W'(1);
               end
            end
            S_PAR: begin
               data_d  = shreg_q;
               perr_d  = ((bus.in ^ par_q) != mode_q);
               err_inc = perr_d;
               fv_d    = 1'b1;
               par_d   = 1'b0;
               cnt_d   = '0;
               fsm_d   = S_DATA;
            end
            default: begin
               fsm_d = S_DATA;
            end
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         fsm_q   <= S_DATA;
         shreg_q <= '0;
         mode_q  <= 1'b0;
         par_q   <= 1'b0;
         cnt_q   <= '0;
         data_q  <= '0;
         fv_q    <= 1'b0;
         perr_q  <= 1'b0;
      end else begin
         fsm_q   <= fsm_d;
         shreg_q <= shreg_d;
         mode_q  <= mode_d;
         par_q   <= par_d;
         cnt_q   <= cnt_d;
         data_q  <= data_d;
         fv_q    <= fv_d;
         perr_q  <= perr_d;
      end
   end

`ifdef PARITY_ERR_CNT_EN
   logic [ERR_W-1:0] err_cnt_q;

   // Saturates at all-ones; only rst clears it.
   always_ff @(posedge clk) begin
      if (rst) begin
         err_cnt_q <= '0;
      end else if (err_inc && (err_cnt_q != '1)) begin
         err_cnt_q <= err_cnt_q + ERR_W'(1);
      end
   end

   assign err_cnt = err_cnt_q;
`else
   logic unused_err_inc;
   assign unused_err_inc = err_inc;
`endif

   assign bus.state       = par_q;
   assign bus.bit_cnt     = cnt_q;
   assign bus.data_out    = data_q;
   assign bus.frame_valid = fv_q;
   assign bus.parity_err  = perr_q;

endmodule

// File: tb/tb_parity_frame_checker.sv
// ---------------------------------------------------------------------------
// tb_parity_frame_checker
//
// Directed frames from the test plan followed by randomized stream traffic.
// A frame-level reference model (bit queue, ones count) predicts outputs;
// completed frames are pushed to a scoreboard queue that a negedge monitor
// pops whenever the checker raises frame_valid.
// ---------------------------------------------------------------------------
module tb_parity_frame_checker;
   localparam int DATA_W = 8;
   localparam int ERR_W  = 2;
   localparam int CNT_W  = $clog2(DATA_W);
   localparam int CNT_MAX = (1 << ERR_W) - 1;

   logic clk;
   logic rst;

   parity_frame_checker_if #(.DATA_W(DATA_W), .CNT_W(CNT_W)) bus ();

`ifdef PARITY_ERR_CNT_EN
   logic [ERR_W-1:0] err_cnt;
`endif

   parity_frame_checker #(
      .DATA_W (DATA_W),
      .ERR_W  (ERR_W),
      .CNT_W  (CNT_W)
   ) dut (
      .clk     (clk),
      .rst     (rst),
      .bus     (bus.slave)
`ifdef PARITY_ERR_CNT_EN
      ,
      .err_cnt (err_cnt)
`endif
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   typedef struct {
      logic [DATA_W-1:0] data;
      logic              err;
      int                cnt;
   } exp_t;

   exp_t sbq[$];
   exp_t mon_e;

   // Reference model state
   bit                fq[$];
   logic              m_mode;
   logic [DATA_W-1:0] m_data;
   logic              m_err;
   int                m_cnt;
   logic              m_fv;
   bit                armed;

   int checks;
   int errors;

   function automatic void chk(string name, logic [63:0] act, logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
      end
   endfunction

   task automatic model_step(input logic r, input logic v, input logic b,
                             input logic om, input logic ab);
      int                ones;
      logic [DATA_W-1:0] w;
      m_fv = 1'b0;
      if (r) begin
         fq.delete();
         m_mode = 1'b0;
         m_data = '0;
         m_err  = 1'b0;
         m_cnt  = 0;
      end else if (ab) begin
         fq.delete();
      end else if (v) begin
         if (fq.size() < DATA_W) begin
            if (fq.size() == 0) m_mode = om;
            fq.push_back(b);
         end else begin
            ones = int'(b);
            w = '0;
            for (int i = 0; i < DATA_W; i++) begin
               w[i] = fq[i];
               ones += int'(fq[i]);
            end
            m_err  = ((ones % 2) == 1) != m_mode;
            m_data = w;
            if (m_err && m_cnt < CNT_MAX) m_cnt++;
            m_fv = 1'b1;
            sbq.push_back('{w, m_err, m_cnt});
            fq.delete();
         end
      end
   endtask

   task automatic cyc(input logic r, input logic v, input logic b,
                      input logic om, input logic ab);
      rst          = r;
      bus.in_valid = v;
      bus.in       = b;
      bus.odd_mode = om;
      bus.abort    = ab;
      @(posedge clk);
      #1;
      model_step(r, v, b, om, ab);
      armed = 1'b1;
   endtask

   // One full frame; odd_mode flips from bit tog_at on (tog_at<0: never),
   // and `gaps` idle cycles are inserted before bit gap_at.
   task automatic send_frame(input logic [DATA_W-1:0] d, input logic p,
                             input logic om, input int tog_at,
                             input int gap_at, input int gaps);
      for (int i = 0; i <= DATA_W; i++) begin
         if (i == gap_at) begin
            repeat (gaps) cyc(1'b0, 1'b0, 1'b0, om, 1'b0);
         end
         cyc(1'b0, 1'b1, (i < DATA_W) ? d[i] : p,
             (tog_at >= 0 && i >= tog_at) ? ~om : om, 1'b0);
      end
   endtask

   // Monitor: per-cycle register checks plus scoreboard pop on frame_valid.
   always @(negedge clk) begin
      if (armed) begin
         int ones;
         int ecnt;
         ones = 0;
         foreach (fq[i]) ones += int'(fq[i]);
         ecnt = (fq.size() > DATA_W - 1) ? DATA_W - 1 : fq.size();
         chk("frame_valid", 64'(bus.frame_valid), 64'(m_fv));
         chk("state", 64'(bus.state), 64'(ones % 2));
         chk("bit_cnt", 64'(bus.bit_cnt), 64'(ecnt));
         chk("data_out_hold", 64'(bus.data_out), 64'(m_data));
         chk("parity_err_hold", 64'(bus.parity_err), 64'(m_err));
`ifdef PARITY_ERR_CNT_EN
         chk("err_cnt", 64'(err_cnt), 64'(m_cnt));
`endif
         if (bus.frame_valid === 1'b1) begin
            if (sbq.size() == 0) begin
               chk("unexpected_frame", 64'(1), 64'(0));
            end else begin
               mon_e = sbq.pop_front();
               chk("sb_data", 64'(bus.data_out), 64'(mon_e.data));
               chk("sb_parity_err", 64'(bus.parity_err), 64'(mon_e.err));
`ifdef PARITY_ERR_CNT_EN
               chk("sb_err_cnt", 64'(err_cnt), 64'(mon_e.cnt));
`endif
            end
         end
      end
   end

   initial begin
      #2_000_000;
      $display("FAIL watchdog expired checks=%0d", checks);
      $fatal(1, "watchdog");
   end

   initial begin
      checks = 0;
      errors = 0;
      armed  = 1'b0;
      m_mode = 1'b0;
      m_data = '0;
      m_err  = 1'b0;
      m_cnt  = 0;
      m_fv   = 1'b0;

      // Reset
      cyc(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
      cyc(1'b1, 1'b1, 1'b1, 1'b1, 1'b0);
      cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);

      // Even, no error; then even with error; then good frame
      send_frame(8'hA5, 1'b0, 1'b0, -1, -1, 0);
      send_frame(8'hA5, 1'b1, 1'b0, -1, -1, 0);
      send_frame(8'hA5, 1'b0, 1'b0, -1, -1, 0);

      // Odd mode latched at bit 0, toggled from bit 4
      send_frame(8'hA5, 1'b1, 1'b1, 4, -1, 0);
      send_frame(8'hA5, 1'b0, 1'b1, 4, -1, 0);

      // Three idle cycles between bits 3 and 4
      send_frame(8'hA5, 1'b0, 1'b0, -1, 4, 3);

      // Abort after 5 bits, then full frame 0x3C
      for (int i = 0; i < 5; i++) cyc(1'b0, 1'b1, 1'(i & 1), 1'b0, 1'b0);
      cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
      send_frame(8'h3C, 1'b0, 1'b0, -1, -1, 0);

      // abort together with in_valid drops the bit
      for (int i = 0; i < 3; i++) cyc(1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
      cyc(1'b0, 1'b1, 1'b1, 1'b0, 1'b1);
      send_frame(8'h5A, 1'b1, 1'b1, -1, -1, 0);

      // Five bad frames for counter saturation
      for (int k = 0; k < 5; k++) send_frame(8'h01, 1'b0, 1'b0, -1, -1, 0);

      // Reset mid-frame, then 0xFF even
      for (int i = 0; i < 6; i++) cyc(1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
      cyc(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
      send_frame(8'hFF, 1'b0, 1'b0, -1, -1, 0);

      // Randomized stream
      for (int n = 0; n < 1500; n++) begin
         cyc(($urandom_range(0, 199) == 0),
             ($urandom_range(0, 9) < 7),
             1'($urandom),
             1'($urandom),
             ($urandom_range(0, 39) == 0));
      end

      repeat (3) cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
      chk("sb_empty", 64'(sbq.size()), 64'(0));

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
